// File: rtl/cnn_cfg_pkg.sv
// Shared configuration for the conv engine datapath: image geometry,
// derived word counts and the feature-map source state type.
package cnn_cfg_pkg;

  localparam int unsigned IMG_W  = 64;
  localparam int unsigned IMG_H  = 64;
  localparam int unsigned MAX_CI = 32;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned DATA_W = 64;

  localparam int unsigned WPR    = IMG_W * PIX_W / DATA_W;  // words per row
  localparam int unsigned WPC    = WPR * IMG_H;             // words per channel
  localparam int unsigned DEPTH  = WPC * MAX_CI;            // words stored
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned RPW    = AW + 1;                  // read pointer, holds 0..DEPTH
  localparam int unsigned CI_W   = 9;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FIN
  } src_state_t;

  // Channel count actually streamed: requests above capacity are clamped.
  function automatic logic [CI_W-1:0] clamp_ci(input logic [CI_W-1:0] ci);
    return (ci > CI_W'(MAX_CI)) ? CI_W'(MAX_CI) : ci;
  endfunction

endpackage

// File: rtl/ifmap_ram.sv
// Single-port feature-map store with a registered read port (1-cycle latency).
// The read register holds its value between reads and clears on rst; the
// array itself is never cleared.
module ifmap_ram
  import cnn_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array write; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read, held when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ifmap_stream_src.sv
// Feature-map source: host loads the RAM while idle; after start_conv the
// stored words are served one per read_I pull, channel-major linear order.
module ifmap_stream_src
  import cnn_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              start_conv,
  input  logic [8:0]        cfg_ci,
  input  logic              read_I,
  output logic [DATA_W-1:0] Idata,
  output logic              Ivalid,
  output logic              Ilast,
  output logic              busy,
  output logic              done,
  output logic              err_wr_busy
);

  src_state_t       state_q, state_d;
  logic [RPW-1:0]   rp_q, rp_d;
  logic [CI_W-1:0]  eff_ci_q, eff_ci_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CI_W-1:0]  ci_clamped;
  logic [RPW-1:0]   last_rp;
  logic             issue, last_issue;
  logic             host_wr_ok;
  logic [AW-1:0]    ram_addr;

  assign ci_clamped = clamp_ci(cfg_ci);
  assign last_rp    = RPW'(32'(eff_ci_q) * WPC - 1);
  assign host_wr_ok = host_we && !rst && (state_q == IDLE) &&
                      (RPW'(host_addr) < RPW'(DEPTH));
  assign ram_addr   = (state_q == STREAM) ? rp_q[AW-1:0] : host_addr;

  ifmap_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (host_wr_ok),
    .re    (issue),
    .addr  (ram_addr),
    .wdata (host_wdata),
    .rdata (Idata)
  );

  // Run control: start/clamp latch, read pointer advance, end-of-run detect.
  always_comb begin
    state_d    = state_q;
    rp_d       = rp_q;
    eff_ci_d   = eff_ci_q;
    issue      = 1'b0;
    last_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_conv) begin
          eff_ci_d = ci_clamped;
          rp_d     = '0;
          state_d  = (ci_clamped == '0) ? FIN : STREAM;
        end
      end
      STREAM: begin
        if (read_I) begin
          issue = 1'b1;
          rp_d  = rp_q + 1'b1;
          if (rp_q == last_rp) begin
            last_issue = 1'b1;
            state_d    = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output qualifiers line up with the registered RAM read; done follows FIN.
  always_comb begin
    valid_d = issue;
    last_d  = last_issue;
    done_d  = (state_q == FIN);
    err_d   = err_q | (host_we && (state_q != IDLE));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rp_q     <= '0;
      eff_ci_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rp_q     <= rp_d;
      eff_ci_q <= eff_ci_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign Ivalid      = valid_q;
  assign Ilast       = last_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err_wr_busy = err_q;

endmodule

// File: tb/tb_ifmap_stream_src.sv
// Randomized scoreboard bench for ifmap_stream_src. The driver keeps a word
// array of what the host stored and a per-run word budget; each accepted pull
// pushes the expected word and its due cycle, the monitor pops and compares.
module tb_ifmap_stream_src;
  import cnn_cfg_pkg::*;

  localparam int BIG = 32'h7fffffff;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              host_we = 1'b0;
  logic [AW-1:0]     host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              start_conv = 1'b0;
  logic [8:0]        cfg_ci = '0;
  logic              read_I = 1'b0;
  logic [DATA_W-1:0] Idata;
  logic              Ivalid, Ilast, busy, done, err_wr_busy;

  ifmap_stream_src dut (
    .clk         (clk),
    .rst         (rst),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .start_conv  (start_conv),
    .cfg_ci      (cfg_ci),
    .read_I      (read_I),
    .Idata       (Idata),
    .Ivalid      (Ivalid),
    .Ilast       (Ilast),
    .busy        (busy),
    .done        (done),
    .err_wr_busy (err_wr_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    bit          last;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [DEPTH];
  int          busy_lo = 1, busy_hi = 0, done_at = -1, err_from = BIG;
  int          remaining = 0, next_idx = 0;
  logic [63:0] last_data = '0;
  bit          mon_en = 1'b0;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus, with the reference model's view of it.
  task automatic step(input bit req, input bit we, input int unsigned addr,
                      input logic [63:0] wd, input bit st, input int ci);
    bit bsy;
    int eff;
    read_I     = req;
    host_we    = we;
    host_addr  = addr[AW-1:0];
    host_wdata = wd;
    start_conv = st;
    cfg_ci     = ci[8:0];
    bsy = (cyc >= busy_lo) && (cyc <= busy_hi);
    if (we) begin
      if (bsy) begin
        if (err_from > cyc + 1) err_from = cyc + 1;
      end else begin
        model[addr % DEPTH] = wd;
      end
    end
    if (st && !bsy) begin
      eff       = (ci > int'(MAX_CI)) ? int'(MAX_CI) : ci;
      remaining = eff * int'(WPC);
      next_idx  = 0;
      busy_lo   = cyc + 1;
      if (remaining == 0) begin
        busy_hi = cyc + 1;
        done_at = cyc + 2;
      end else begin
        busy_hi = BIG;
        done_at = -1;
      end
    end else if (req && remaining > 0) begin
      sb.push_back('{data: model[next_idx], last: (remaining == 1), due: cyc + 1});
      next_idx++;
      remaining--;
      if (remaining == 0) begin
        busy_hi = cyc + 1;
        done_at = cyc + 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic do_start(input int ci);
    step(1'b0, 1'b1, $urandom_range(0, 511), {$urandom(), $urandom()}, 1'b1, ci);
  endtask

  task automatic run_pct(input int pct);
    for (int k = 0; k < 100000 && remaining > 0; k++)
      step($urandom_range(0, 99) < pct, 1'b0, 0, '0, 1'b0, $urandom_range(0, 511));
    chk("run_complete", remaining, 0);
  endtask

  task automatic finish_run();
    for (int k = 0; k < 6; k++)
      step($urandom_range(0, 1), 1'b0, 0, '0, 1'b0, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic rst_step();
    rst        = 1'b1;
    read_I     = $urandom_range(0, 1);
    host_we    = 1'b0;
    start_conv = 1'b0;
    busy_hi    = cyc;
    done_at    = -1;
    remaining  = 0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    err_from  = BIG;
    last_data = '0;
  endtask

  // Monitor: stream words against the scoreboard, status against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      chk("done", done, cyc == done_at);
      chk("err_wr_busy", err_wr_busy, cyc >= err_from);
      if (Ivalid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", Ivalid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("idata", Idata, e.data);
          chk("ilast", Ilast, e.last);
          chk("valid_cycle", cyc, e.due);
          last_data = e.data;
        end
      end else begin
        chk("idata_hold", Idata, last_data);
        chk("ilast_idle", Ilast, 1'b0);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
          void'(sb.pop_front());
          chk("missing_word", Ivalid, 1'b1);
        end
      end
    end
  end

  initial begin
    #(95000 * 10);
    fails++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < int'(DEPTH); a++) model[a] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_idata", Idata, '0);
    chk("rst_ivalid", Ivalid, 1'b0);
    chk("rst_ilast", Ilast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_wr_busy, 1'b0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Load the whole store; low word carries the address for readability.
    for (int a = 0; a < int'(DEPTH); a++)
      step(1'b0, 1'b1, a, {$urandom(), a[31:0]}, 1'b0, 0);
    idle_step();

    // One channel, pull every cycle (plus a same-cycle host write at start).
    do_start(1);
    run_pct(100);
    finish_run();

    // Two channels, alternating pulls.
    do_start(2);
    for (int k = 0; k < 100000 && remaining > 0; k++)
      step(k % 2 == 0, 1'b0, 0, '0, 1'b0, 0);
    chk("run_complete", remaining, 0);
    finish_run();

    // Zero channels: no words, FIN straight away.
    do_start(0);
    finish_run();

    // Oversized request clamps; busy write and re-start are both ignored.
    do_start(40);
    step(1'b0, 1'b1, 5, 64'hFFFF, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, $urandom_range(1, 3));
    run_pct(75);
    finish_run();

    // A few random runs with random pull density.
    for (int r = 0; r < 3; r++) begin
      do_start($urandom_range(1, 3));
      run_pct($urandom_range(50, 100));
      finish_run();
    end

    // Reset mid-run after 100 words, then a fresh run from word 0.
    do_start(3);
    for (int k = 0; k < 1000 && next_idx < 100; k++)
      step(1'b1, 1'b0, 0, '0, 1'b0, 0);
    rst_step();
    idle_step();
    do_start(1);
    run_pct(60);
    finish_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
